// File: rtl/tetris_input_arbiter_pkg.sv
// tetris_input_arbiter_pkg: shared command encoding, UART key constants and key decode
package tetris_input_arbiter_pkg;
  typedef enum logic [3:0] {
    CMD_NONE    = 4'd0,
    CMD_LEFT    = 4'd1,
    CMD_RIGHT   = 4'd2,
    CMD_DOWN    = 4'd3,
    CMD_ROTATE  = 4'd4,
    CMD_DROP    = 4'd5,
    CMD_HOLD    = 4'd6,
    CMD_PAUSE   = 4'd7,
    CMD_RESTART = 4'd8
  } cmd_type_t;
  localparam logic [7:0] KEY_LEFT    = 8'h61;
  localparam logic [7:0] KEY_RIGHT   = 8'h64;
  localparam logic [7:0] KEY_DOWN    = 8'h73;
  localparam logic [7:0] KEY_ROTATE  = 8'h77;
  localparam logic [7:0] KEY_DROP    = 8'h20;
  localparam logic [7:0] KEY_HOLD    = 8'h63;
  localparam logic [7:0] KEY_PAUSE   = 8'h70;
  localparam logic [7:0] KEY_RESTART = 8'h72;
  // Only A-Z are folded to lower case; folding every byte would alias e.g. 0x00 onto space.
  function automatic cmd_type_t decode_key(input logic [7:0] b);
    logic [7:0] l;
    l = (b >= 8'h41 && b <= 8'h5a) ? (b | 8'h20) : b;
    case (l)
      KEY_LEFT:    return CMD_LEFT;
      KEY_RIGHT:   return CMD_RIGHT;
      KEY_DOWN:    return CMD_DOWN;
      KEY_ROTATE:  return CMD_ROTATE;
      KEY_DROP:    return CMD_DROP;
      KEY_HOLD:    return CMD_HOLD;
      KEY_PAUSE:   return CMD_PAUSE;
      KEY_RESTART: return CMD_RESTART;
      default:     return CMD_NONE;
    endcase
  endfunction
endpackage

// File: rtl/tetris_input_arbiter_btn_debounce.sv
// btn_debounce: 2-FF synchroniser, debounce counter and optional auto-repeat timer
// Ports: clk, reset_n (async active-low), btn_raw (async button), event_o (press/repeat pulse)
// Macro TETRIS_AUTO_REPEAT_EN adds the repeat timer, enabled per instance by REPEAT_EN.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 1_000_000
`ifdef TETRIS_AUTO_REPEAT_EN
  ,
  parameter int REPEAT_DELAY_CYC = 15_000_000,
  parameter int REPEAT_RATE_CYC  = 5_000_000,
  parameter bit REPEAT_EN        = 1'b1
`endif
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic event_o
);
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  logic [1:0]    sync_q;
  logic          level_q, level_d, rise;
  logic [DW-1:0] cnt_q, cnt_d;
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == DW'(DEBOUNCE_CYC - 1)) level_d = sync_q[1];
      else cnt_d = cnt_q + 1'b1;
    end
  end
  assign rise = level_d & ~level_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], btn_raw};
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end
`ifdef TETRIS_AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY_CYC + 1);
  logic [RW-1:0] rep_q, rep_d;
  logic          rep_hit;
  // rep_q holds cycles since the press; after each hit it is rewound so the next
  // hit lands REPEAT_RATE_CYC cycles later.
  assign rep_hit = REPEAT_EN && level_q && rep_q == RW'(REPEAT_DELAY_CYC);
  assign rep_d   = rise ? RW'(1) : !level_q ? '0 :
                   rep_hit ? RW'(REPEAT_DELAY_CYC - REPEAT_RATE_CYC + 1) : rep_q + 1'b1;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rep_q <= '0;
    else rep_q <= rep_d;
  end
  assign event_o = rise | rep_hit;
`else
  assign event_o = rise;
`endif
endmodule

// File: rtl/tetris_input_arbiter.sv
// tetris_input_arbiter: merges debounced buttons and UART keys into a command FIFO
// Ports: clk, reset_n (async active-low), usr_btn[3:0] {LEFT,DOWN,ROTATE,RIGHT},
//        rx_valid/rx_data (UART byte), cmd_ready/cmd_valid/cmd (show-ahead FIFO head),
//        drop_cnt (saturating count of events lost to an occupied pending slot)
// Macro TETRIS_AUTO_REPEAT_EN enables auto-repeat on LEFT/RIGHT/DOWN buttons.
module tetris_input_arbiter
  import tetris_input_arbiter_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000,
`ifdef TETRIS_AUTO_REPEAT_EN
  parameter int REPEAT_DELAY_CYC = 15_000_000,
  parameter int REPEAT_RATE_CYC  = 5_000_000,
`endif
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] usr_btn,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [3:0] cmd,
  output logic [7:0] drop_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [3:0]    btn_ev;
  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
`ifdef TETRIS_AUTO_REPEAT_EN
      ,
      .REPEAT_DELAY_CYC(REPEAT_DELAY_CYC),
      .REPEAT_RATE_CYC(REPEAT_RATE_CYC),
      .REPEAT_EN(i != 1)
`endif
    ) u_btn (
      .clk(clk),
      .reset_n(reset_n),
      .btn_raw(usr_btn[i]),
      .event_o(btn_ev[i])
    );
  end
  cmd_type_t     rx_cmd, ucmd_q, ucmd_d, wr_cmd;
  cmd_type_t     mem_q [FIFO_DEPTH];
  cmd_type_t     mem_d [FIFO_DEPTH];
  logic [4:0]    pend_q, pend_d, ev, grant, wr, drop;
  logic [7:0]    drop_q, drop_d;
  logic [8:0]    drop_sum;
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push, pop, full;
  // Source 0 is the UART, sources 1..4 are buttons 0..3; lowest index wins.
  assign rx_cmd   = decode_key(rx_data);
  assign ev       = {btn_ev, rx_valid && rx_cmd != CMD_NONE};
  assign grant    = pend_q & (~pend_q + 5'd1);
  assign full     = cnt_q == (AW + 1)'(FIFO_DEPTH);
  assign pop      = cmd_valid && cmd_ready;
  assign push     = |grant && (!full || pop);
  assign wr       = push ? grant : '0;
  assign wr_cmd   = grant[0] ? ucmd_q : grant[1] ? CMD_RIGHT : grant[2] ? CMD_ROTATE :
                    grant[3] ? CMD_DOWN : CMD_LEFT;
  // A slot being written this cycle is free again, so a new event there is kept.
  assign drop     = ev & pend_q & ~wr;
  assign drop_sum = 9'(drop_q) + 9'($countones(drop));
  always_comb begin
    pend_d = (pend_q & ~wr) | ev;
    ucmd_d = (ev[0] && !drop[0]) ? rx_cmd : ucmd_q;
    drop_d = drop_sum[8] ? 8'hff : drop_sum[7:0];
    mem_d  = mem_q;
    if (push) mem_d[wp_q] = wr_cmd;
    wp_d   = wp_q + AW'(push);
    rp_d   = rp_q + AW'(pop);
    cnt_d  = cnt_q + (AW + 1)'(push) - (AW + 1)'(pop);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q <= '0;
      ucmd_q <= CMD_NONE;
      drop_q <= '0;
      mem_q  <= '{default: CMD_NONE};
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      ucmd_q <= ucmd_d;
      drop_q <= drop_d;
      mem_q  <= mem_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      cnt_q  <= cnt_d;
    end
  end
  assign cmd_valid = cnt_q != '0;
  assign cmd       = cmd_valid ? mem_q[rp_q] : CMD_NONE;
  assign drop_cnt  = drop_q;
endmodule

// File: doc/tetris_input_arbiter.md
Name: tetris_input_arbiter

Overview:
Upstream front end for the tetris core. It merges the four board buttons and decoded UART key bytes into a single stream of one-hot-free game commands. Buttons are synchronised, debounced and optionally auto-repeated; all events pass through a small command FIFO. The tetris core consumes the FIFO over a valid/ready handshake.

Parameters:
DEBOUNCE_CYC, 1_000_000, consecutive stable cycles before a debounced level changes (20 ms at 50 MHz)
REPEAT_DELAY_CYC, 15_000_000, hold time from press to first auto-repeat (300 ms)
REPEAT_RATE_CYC, 5_000_000, interval between subsequent auto-repeats (100 ms)
FIFO_DEPTH, 4, command FIFO entries; power of two, at least 2

Ports:
clk  in  1  system clock (50 MHz domain)
reset_n  in  1  asynchronous active-low reset
usr_btn  in  4  raw asynchronous buttons: [0]=RIGHT, [1]=ROTATE, [2]=DOWN, [3]=LEFT
rx_valid  in  1  one-cycle strobe; rx_data holds a received byte
rx_data  in  8  ASCII byte from the UART receiver
cmd_ready  in  1  tetris core accepts the head command this cycle
cmd_valid  out  1  FIFO non-empty
cmd  out  4  cmd_type of the head entry; NONE when cmd_valid=0
drop_cnt  out  8  saturating count of discarded events

Behaviour:
- Reset, asynchronous: cmd_valid=0, cmd=NONE, drop_cnt=0, FIFO empty, all pending bits clear, synchronisers 0, debounced levels 0, timers 0.
- cmd_type encoding, 4 bits: NONE=0, LEFT=1, RIGHT=2, DOWN=3, ROTATE=4, DROP=5, HOLD=6, PAUSE=7, RESTART=8.
- Button path, per bit:
  - 2-FF synchroniser feeds the debounce counter.
  - The counter resets whenever the synced input equals the debounced level.
  - When the counter reaches DEBOUNCE_CYC-1 while the input differs, the debounced level flips.
  - A press event is a debounced 0->1 transition.
- UART decode, case-insensitive letters:
  - a=LEFT, d=RIGHT, s=DOWN, w=ROTATE, space=DROP, c=HOLD, p=PAUSE, r=RESTART.
  - Any other byte is ignored silently; it is not a drop.
- Event capture and arbitration:
  - Each source (uart, btn0..btn3) has one pending flag plus its command.
  - An event arriving while that source's pending flag is already set is discarded and drop_cnt increments, saturating at 255.
  - Each cycle, at most one pending source is written to the FIFO when it is not full, or when a pop occurs in the same cycle.
  - Arbitration priority: uart, then btn0, btn1, btn2, btn3. The written source clears its pending flag.
  - While the FIFO is full without a pop, pending flags hold. Nothing is lost beyond the single-slot pending.
- FIFO:
  - Show-ahead. A pop occurs when cmd_valid && cmd_ready.
  - Simultaneous push and pop on a full FIFO is legal; the count is unchanged.
  - cmd_ready with an empty FIFO has no effect.
- Latency, idle and empty FIFO:
  - rx_valid at cycle t: pending at t+1, written at the end of t+1, cmd_valid=1 at t+2.
  - Button press event at cycle t: the same t+2 rule applies.
- drop_cnt is never cleared except by reset.
- Reset mid-operation clears everything. A button still held after reset release yields exactly one press event once debounced.

Optional Feature:
- Macro: TETRIS_AUTO_REPEAT_EN.
- Defined:
  - For LEFT, RIGHT and DOWN buttons only, while the debounced level stays 1, a repeat timer counts from the press.
  - A repeat event is emitted at REPEAT_DELAY_CYC cycles after the press, then every REPEAT_RATE_CYC cycles.
  - Release clears the timer.
  - Repeats use the normal pending/drop rules.
- Undefined: only press edges generate events; no repeat timers are synthesised.

Decomposition:
- cmd_type enum (4-bit, values above) goes in the shared package enum_type alongside state_type.
- The ASCII key constants also go in that package.
- One sub-module, btn_debounce: synchroniser, debounce counter and repeat timer under the macro. It is instantiated four times, with a repeat-enable parameter per instance.

Test Plan:
- Test parameters: DEBOUNCE_CYC=4, REPEAT_DELAY_CYC=20, REPEAT_RATE_CYC=8, FIFO_DEPTH=4.
- UART byte "A" with cmd_ready=1 → cmd_valid pulses exactly 2 cycles later with cmd=1 (LEFT). Byte "x" → no event and drop_cnt stays 0.
- usr_btn[1] glitch high for 3 cycles → no event. Held 10 cycles → exactly one ROTATE(4), with no repeat even when the macro is defined.
- Macro defined, usr_btn[0] held 50 cycles after debounce → RIGHT(2) at press, then at +20, +28, +36 and +44 cycles (5 total).
- cmd_ready=0 and 6 distinct UART commands spaced 3 cycles apart:
  - FIFO fills with the first 4 and the 5th stays pending.
  - The 6th increments drop_cnt to 1.
  - Raising cmd_ready drains 5 commands in order.
- Same-cycle rx_valid "d" and btn3 press → RIGHT then LEFT on consecutive accepted beats.
- Assert reset_n low mid-burst with a full FIFO → cmd_valid=0, cmd=NONE and drop_cnt=0 immediately (asynchronously). The held button yields one event after release of reset.
